mem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single-port 128x8 data memory (negedge-clocked write, negedge-registered read) between requester A (CPU datapath) and requester B (I/O/loader port). It accepts held requests, issues at most one memory access per cycle, and returns read data with a one-cycle valid pulse to the requester that issued the read. It sits directly between the requesters and the memory's `we`/`address`/`data_in`/`data_out` pins.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter: two-requester round-robin arbiter in front of a single-port
// data memory (negedge write, negedge-registered read).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    input  logic              req_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    output logic              gnt_a_o,
    output logic              gnt_b_o,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic              rvalid_a_o,
    output logic              rvalid_b_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    logic              gnt_a_q, gnt_b_q;
    logic              rvalid_a_q, rvalid_b_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              last_winner_q;
    logic              pend_valid_q;
    logic              pend_id_q;

    logic              elig_a_d, elig_b_d;
    logic              gnt_a_d, gnt_b_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    // A request just granted is not re-sampled, so a lone requester issues
    // at most every other cycle and never double-issues a held request.
    always_comb begin
        elig_a_d    = req_a_i && !gnt_a_q;
        elig_b_d    = req_b_i && !gnt_b_q;
        gnt_a_d     = elig_a_d && (!elig_b_d || (last_winner_q == OWNER_B));
        gnt_b_d     = elig_b_d && !gnt_a_d;
        sel_we_d    = gnt_a_d ? we_a_i    : we_b_i;
        sel_addr_d  = gnt_a_d ? addr_a_i  : addr_b_i;
        sel_wdata_d = gnt_a_d ? wdata_a_i : wdata_b_i;
    end

    // Async reset also drops mem_we before the falling edge, which is what
    // suppresses a write caught by reset in its issue cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            rvalid_a_q    <= 1'b0;
            rvalid_b_q    <= 1'b0;
            rdata_a_q     <= '0;
            rdata_b_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            last_winner_q <= OWNER_B;
            pend_valid_q  <= 1'b0;
            pend_id_q     <= OWNER_A;
        end else begin
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;

            if (gnt_a_d || gnt_b_d) begin
                mem_we_q      <= sel_we_d;
                mem_addr_q    <= sel_addr_d;
                mem_din_q     <= sel_wdata_d;
                last_winner_q <= gnt_b_d;
                pend_valid_q  <= !sel_we_d;
                pend_id_q     <= gnt_b_d;
            end else begin
                mem_we_q     <= 1'b0;
                pend_valid_q <= 1'b0;
            end

            rvalid_a_q <= pend_valid_q && (pend_id_q == OWNER_A);
            rvalid_b_q <= pend_valid_q && (pend_id_q == OWNER_B);
            if (pend_valid_q && (pend_id_q == OWNER_A)) begin
                rdata_a_q <= mem_dout_i;
            end
            if (pend_valid_q && (pend_id_q == OWNER_B)) begin
                rdata_b_q <= mem_dout_i;
            end
        end
    end

    assign gnt_a_o    = gnt_a_q;
    assign gnt_b_o    = gnt_b_q;
    assign rdata_a_o  = rdata_a_q;
    assign rdata_b_o  = rdata_b_q;
    assign rvalid_a_o = rvalid_a_q;
    assign rvalid_b_o = rvalid_b_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// behavioural 128x8 negedge memory.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem [0:127];

    int checks;
    int failures;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_a_i    (req_a),
        .we_a_i     (we_a),
        .addr_a_i   (addr_a),
        .wdata_a_i  (wdata_a),
        .req_b_i    (req_b),
        .we_b_i     (we_b),
        .addr_b_i   (addr_b),
        .wdata_b_i  (wdata_b),
        .gnt_a_o    (gnt_a),
        .gnt_b_o    (gnt_b),
        .rdata_a_o  (rdata_a),
        .rdata_b_o  (rdata_b),
        .rvalid_a_o (rvalid_a),
        .rvalid_b_o (rvalid_b),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_din_o  (mem_din),
        .mem_dout_i (mem_dout)
    );

    always #5 clk = ~clk;

    // Old-data read: both updates at the same falling edge.
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt_a"},    gnt_a,    0);
        check({tag, "_gnt_b"},    gnt_b,    0);
        check({tag, "_mem_we"},   mem_we,   0);
        check({tag, "_rvalid_a"}, rvalid_a, 0);
        check({tag, "_rvalid_b"}, rvalid_b, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        mem_dout = '0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h00] = 8'hAB;
        mem[7'h01] = 8'h11;
        mem[7'h02] = 8'h22;
        mem[7'h20] = 8'h77;

        // Reset held 3 cycles with both requesters asking to write
        req_a = 1; we_a = 1; addr_a = 7'h33; wdata_a = 8'h99;
        req_b = 1; we_b = 1; addr_b = 7'h34; wdata_b = 8'h98;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("rst");
            check("rst_addr",  mem_addr, 0);
            check("rst_din",   mem_din,  0);
            check("rst_rdata_a", rdata_a, 0);
            check("rst_rdata_b", rdata_b, 0);
        end
        check("rst_nowrite_a", mem[7'h33], 8'h00);
        check("rst_nowrite_b", mem[7'h34], 8'h00);

        rst_n = 1;
        tick();
        check("first_gnt_a", gnt_a, 1);
        check("first_gnt_b", gnt_b, 0);
        check("first_addr",  mem_addr, 7'h33);
        check("first_we",    mem_we, 1);
        req_a = 0;
        tick();
        check("second_gnt_b", gnt_b, 1);
        check("second_gnt_a", gnt_a, 0);
        check("second_addr",  mem_addr, 7'h34);
        req_b = 0;
        tick();
        check_idle("post_rst_idle");
        check("addr_hold", mem_addr, 7'h34);
        check("wr_a_done", mem[7'h33], 8'h99);
        check("wr_b_done", mem[7'h34], 8'h98);

        // Lone write then read by A
        req_a = 1; we_a = 1; addr_a = 7'h10; wdata_a = 8'h5A;
        tick();
        check("lone_wr_gnt", gnt_a, 1);
        check("lone_wr_we",  mem_we, 1);
        we_a = 0;
        tick();
        check("lone_gap_gnt", gnt_a, 0);
        check("lone_gap_we",  mem_we, 0);
        tick();
        check("lone_rd_gnt",  gnt_a, 1);
        check("lone_rd_we",   mem_we, 0);
        check("lone_rd_addr", mem_addr, 7'h10);
        req_a = 0;
        tick();
        check("lone_rvalid_a", rvalid_a, 1);
        check("lone_rdata_a",  rdata_a, 8'h5A);
        check("lone_rvalid_b", rvalid_b, 0);
        check("lone_gnt_a_off", gnt_a, 0);
        tick();
        check("lone_rvalid_off", rvalid_a, 0);

        // Contention: last winner is A, so B leads, then strict alternation
        req_a = 1; we_a = 0; addr_a = 7'h01;
        req_b = 1; we_b = 0; addr_b = 7'h02;
        tick();
        check("ct1_gnt_b", gnt_b, 1);
        check("ct1_gnt_a", gnt_a, 0);
        tick();
        check("ct2_gnt_a", gnt_a, 1);
        check("ct2_gnt_b", gnt_b, 0);
        check("ct2_rvalid_b", rvalid_b, 1);
        check("ct2_rdata_b",  rdata_b, 8'h22);
        check("ct2_rvalid_a", rvalid_a, 0);
        tick();
        check("ct3_gnt_b", gnt_b, 1);
        check("ct3_rvalid_a", rvalid_a, 1);
        check("ct3_rdata_a",  rdata_a, 8'h11);
        check("ct3_rvalid_b", rvalid_b, 0);
        tick();
        check("ct4_gnt_a", gnt_a, 1);
        check("ct4_rvalid_b", rvalid_b, 1);
        check("ct4_rdata_b",  rdata_b, 8'h22);
        req_a = 0; req_b = 0;
        tick();
        check("ct5_rvalid_a", rvalid_a, 1);
        check("ct5_rdata_a",  rdata_a, 8'h11);
        check("ct5_gnt_a", gnt_a, 0);
        check("ct5_gnt_b", gnt_b, 0);

        // B writes top address, A reads it back on the very next cycle
        req_b = 1; we_b = 1; addr_b = 7'h7F; wdata_b = 8'hC3;
        tick();
        check("raw_gnt_b", gnt_b, 1);
        check("raw_we",    mem_we, 1);
        req_b = 0;
        req_a = 1; we_a = 0; addr_a = 7'h7F;
        tick();
        check("raw_gnt_a", gnt_a, 1);
        check("raw_rd_we", mem_we, 0);
        req_a = 0;
        tick();
        check("raw_rvalid_a", rvalid_a, 1);
        check("raw_rdata_a",  rdata_a, 8'hC3);
        check("raw_rdata_b_hold", rdata_b, 8'h22);

        // Bottom address read, then idle holds address
        req_a = 1; we_a = 0; addr_a = 7'h00;
        tick();
        check("wrap_gnt_a", gnt_a, 1);
        check("wrap_addr",  mem_addr, 7'h00);
        req_a = 0;
        tick();
        check("wrap_rvalid_a", rvalid_a, 1);
        check("wrap_rdata_a",  rdata_a, 8'hAB);
        tick();
        check_idle("wrap_idle");
        check("wrap_addr_hold", mem_addr, 7'h00);

        // Reset lands after B's write issues but before the falling edge
        req_b = 1; we_b = 1; addr_b = 7'h20; wdata_b = 8'hFF;
        tick();
        check("mid_gnt_b", gnt_b, 1);
        check("mid_we",    mem_we, 1);
        rst_n = 0;
        #1;
        check_idle("mid_rst");
        req_a = 1; we_a = 0; addr_a = 7'h02;
        tick();
        tick();
        check("mid_nowrite", mem[7'h20], 8'h77);
        check_idle("mid_rst_hold");
        rst_n = 1;
        tick();
        check("mid_first_gnt_a", gnt_a, 1);
        check("mid_first_gnt_b", gnt_b, 0);

        // Reset discards an in-flight read
        rst_n = 0; req_a = 0; req_b = 0;
        #1;
        check("flight_rvalid_a_now", rvalid_a, 0);
        tick();
        check("flight_rvalid_a", rvalid_a, 0);
        check("flight_rdata_a",  rdata_a, 0);
        rst_n = 1;
        tick();
        check_idle("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
